// File: rtl/rs5_hpm_counter_unit.sv
// Machine-mode hardware performance monitor: programmable event counters,
// event selectors with sticky overflow flags, an inhibit mask and an overflow interrupt.
module rs5_hpm_counter_unit #(
    parameter int NUM_COUNTERS  = 4,
    parameter int NUM_EVENTS    = 16,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_EVENTS-1:0]   event_i,
    input  logic [11:0]             csr_addr_i,
    input  logic                    csr_wr_en_i,
    input  logic [31:0]             csr_wr_data_i,
    input  logic                    csr_rd_en_i,
    output logic [31:0]             csr_rd_data_o,
    output logic                    csr_hit_o,
    output logic [NUM_COUNTERS-1:0] overflow_o,
    output logic                    ovf_irq_o
);

    localparam int NC = NUM_COUNTERS;
    localparam int CW = COUNTER_WIDTH;

    logic [CW-1:0]  r_cnt [NC];
    logic [4:0]     r_sel [NC];
    logic [NC-1:0]  r_of;
    logic [NC-1:0]  r_inh;
    logic [31:0]    r_rd_data;
    logic           r_hit;
    logic           r_irq;

    logic [6:0]     w_grp;
    logic [4:0]     w_k;
    logic           w_in_cnt_lo;
    logic           w_in_cnt_hi;
    logic           w_in_evt;
    logic           w_in_inh;
    logic           w_inh_wr;
    logic [31:0]    w_ev_ext;
    logic [NC-1:0]  w_lo_wr;
    logic [NC-1:0]  w_hi_wr;
    logic [NC-1:0]  w_ev_wr;
    logic [NC-1:0]  w_inc;
    logic [NC-1:0]  w_wrap;
    logic [31:0]    w_rd_data;
    logic           w_hit;

    // Owned windows are the 32-entry blocks at 0xB00/0xB80/0x320, excluding indices 0..2.
    assign w_grp       = csr_addr_i[11:5];
    assign w_k         = csr_addr_i[4:0];
    assign w_in_cnt_lo = (w_grp == 7'h58) && (w_k >= 5'd3);
    assign w_in_cnt_hi = (w_grp == 7'h5C) && (w_k >= 5'd3);
    assign w_in_evt    = (w_grp == 7'h19) && (w_k >= 5'd3);
    assign w_in_inh    = (csr_addr_i == 12'h320);
    assign w_inh_wr    = csr_wr_en_i && w_in_inh;

    // Bit 0 stays 0 so a selector of 0 or above NUM_EVENTS lands on a zero bit.
    assign w_ev_ext = 32'({event_i, 1'b0});

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_cnt
            localparam logic [4:0] K = 5'(gi + 3);
            assign w_lo_wr[gi] = csr_wr_en_i && w_in_cnt_lo && (w_k == K);
            assign w_hi_wr[gi] = csr_wr_en_i && w_in_cnt_hi && (w_k == K);
            assign w_ev_wr[gi] = csr_wr_en_i && w_in_evt && (w_k == K);
            assign w_inc[gi]   = !r_inh[gi] && w_ev_ext[r_sel[gi]]
                                 && !w_lo_wr[gi] && !w_hi_wr[gi];
            assign w_wrap[gi]  = w_inc[gi] && (&r_cnt[gi]);
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        w_hit     = w_in_cnt_lo || w_in_cnt_hi || w_in_evt || w_in_inh;
        if (w_in_inh) begin
            w_rd_data = 32'({r_inh, 3'b000});
        end
        for (int i = 0; i < NC; i++) begin
            if (w_k == 5'(i + 3)) begin
                if (w_in_cnt_lo) w_rd_data = r_cnt[i][31:0];
                if (w_in_cnt_hi) w_rd_data = 32'(r_cnt[i][CW-1:32]);
                if (w_in_evt)    w_rd_data = {r_of[i], 26'b0, r_sel[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++) begin
                r_cnt[i] <= '0;
                r_sel[i] <= '0;
            end
            r_of      <= '0;
            r_inh     <= '0;
            r_rd_data <= '0;
            r_hit     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                // A write to either half suppresses the increment, so no carry crosses halves.
                if (w_lo_wr[i]) begin
                    r_cnt[i][31:0] <= csr_wr_data_i;
                end else if (w_hi_wr[i]) begin
                    r_cnt[i][CW-1:32] <= csr_wr_data_i[CW-33:0];
                end else if (w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
                if (w_ev_wr[i]) begin
                    r_sel[i] <= csr_wr_data_i[4:0];
                    r_of[i]  <= csr_wr_data_i[31];
                end else if (w_wrap[i]) begin
                    r_of[i] <= 1'b1;
                end
            end
            if (w_inh_wr) begin
                r_inh <= csr_wr_data_i[3 +: NC];
            end
            if (csr_rd_en_i) begin
                r_rd_data <= w_rd_data;
                r_hit     <= w_hit;
            end
            r_irq <= |(r_of & ~r_inh);
        end
    end

    assign csr_rd_data_o = r_rd_data;
    assign csr_hit_o     = r_hit;
    assign overflow_o    = r_of;
    assign ovf_irq_o     = r_irq;

endmodule

// File: doc/rs5_hpm_counter_unit.md
Name: rs5_hpm_counter_unit

Overview:
- Parametrised machine-mode hardware performance monitor for RS5.
- Implements NUM_COUNTERS programmable event counters mapped at mhpmcounter3.. (0xB03+), their high halves at mhpmcounterh (0xB83+), event selectors at mhpmevent (0x323+), and inhibit bits in mcountinhibit (0x320).
- Sits beside the CSR bank: the CSR bank forwards matching accesses, and the pipeline drives one-hot-per-cycle event strobes.
- Adds sticky per-counter overflow flags and an overflow interrupt request.

Parameters:
NUM_COUNTERS, 4, number of implemented counters starting at index 3; legal range 1..29.
NUM_EVENTS, 16, width of the event strobe bus; legal range 1..31.
COUNTER_WIDTH, 64, implemented counter bits; legal range 33..64. Unimplemented upper bits read 0.

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
event_i  in  NUM_EVENTS  event strobes; a bit held high for one cycle counts as one event
csr_addr_i  in  12  CSR address
csr_wr_en_i  in  1  write strobe, single cycle
csr_wr_data_i  in  32  write data (final value; the CSR bank has already resolved set/clear)
csr_rd_en_i  in  1  read strobe
csr_rd_data_o  out  32  read data, 1-cycle latency
csr_hit_o  out  1  address is owned by this block; valid together with csr_rd_data_o
overflow_o  out  NUM_COUNTERS  sticky overflow flags (OF bits)
ovf_irq_o  out  1  registered OR of overflow flags whose counter is not inhibited

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all counters = 0, all selectors = 0, all OF = 0, inhibit = 0.
  - csr_rd_data_o = 0, csr_hit_o = 0, ovf_irq_o = 0.
  - Reset mid-operation takes priority over any write or increment in that cycle.
- Counter i (index k = i+3):
  - Register fields: sel_i[4:0] = mhpmevent[k][4:0]; OF_i = mhpmevent[k][31].
  - Increment condition for counter i: inh_k == 0, 1 <= sel_i <= NUM_EVENTS, and event_i[sel_i-1] == 1.
  - sel_i = 0 or sel_i > NUM_EVENTS → never counts. The stored value still reads back as written.
  - Increments by exactly 1 per cycle; multiple events are not accumulated.
- Wrap-around:
  - On increment from 2^COUNTER_WIDTH-1, the counter becomes 0 and OF_i is set in the same edge.
  - OF_i is sticky; it is cleared only by a mhpmevent write with bit31 = 0. Writing bit31 = 1 sets it.
- Writes:
  - Write to 0xB03+i replaces bits [31:0]. Write to 0xB83+i replaces bits [COUNTER_WIDTH-1:32].
  - Write beats increment: a counter written in a cycle does not increment in that cycle, and no carry propagates into the unwritten half.
  - mhpmevent writes store bits [4:0] and [31]; all other bits read 0.
  - mcountinhibit (0x320) stores bits [3+NUM_COUNTERS-1:3]; other bits read 0 and are not owned here (the CSR bank merges CY/IR).
  - A write to an inhibit bit takes effect from the next cycle.
- Reads:
  - csr_rd_en_i at edge t → csr_rd_data_o and csr_hit_o are valid after edge t+1 and hold until the next read.
  - Read data is the pre-update value from cycle t.
  - mhpmevent reads include the live OF bit.
- Address ownership:
  - Owned addresses: 0xB03-0xB1F, 0xB83-0xB9F, 0x323-0x33F, 0x320.
  - Owned but unimplemented indices (k >= 3+NUM_COUNTERS) read 0, ignore writes, and report csr_hit_o = 1.
  - Non-owned address: csr_hit_o = 0, data = 0, writes ignored.
- Interrupt: ovf_irq_o = |(OF & ~inh), registered, so it has 1-cycle latency from the OF set.
- Simultaneous read and write to the same CSR in one cycle returns the old value.
- Simultaneous wrap and mhpmevent write with bit31 = 0 in one cycle: the write wins, and OF ends at 0.

Test Plan:
1. Reset, then select event 2 on counter3 (write 0x323 = 0x2) and pulse event_i[1] for 7 cycles → reading 0xB03 returns 7, reading 0xB83 returns 0, and csr_hit_o = 1 one cycle after csr_rd_en_i.
2. Write 0xB03 = 0xFFFFFFFE and 0xB83 = 0xFFFFFFFF, then apply 3 events → counter reads 1, OF_0 = 1, 0x323 reads 0x80000002, and ovf_irq_o rises one cycle after the wrap.
3. Write 0x320 = 0x8 with events active → counter3 frozen and ovf_irq_o masked. Write 0x320 = 0 → counting resumes the following cycle.
4. Write 0xB03 = 0x100 in the same cycle as an event → counter reads 0x100, not 0x101. A low write with the counter at 0xFFFFFFFF leaves the high half unchanged.
5. With NUM_COUNTERS = 4, read 0xB10 → 0 with hit = 1. Read 0x7C0 → hit = 0. Write 0x324 = 0x1F with NUM_EVENTS = 16 → reads back 0x1F and counter4 never increments.
6. Assert reset_n = 0 for one edge during active counting with OF set → all counters, OF, ovf_irq_o and read outputs are 0 after that edge.
